branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001: Parameter IDX_BITS, default 6, SHALL set the table to 2^IDX_BITS entries.
REQ-002: Parameter ADDR_W, default 32, SHALL set the PC and target width.
REQ-003: Port clk, input, 1, SHALL be the single clock; every state element updates on its rising edge.
REQ-004: Port reset_n, input, 1, SHALL be the reset: synchronous, active-low.
REQ-005: Port fetch_pc, input, ADDR_W, SHALL carry the fetch-stage PC to predict.
REQ-006: Port predict_taken, output, 1, SHALL carry the taken prediction for fetch_pc.
REQ-007: Port predict_target, output, ADDR_W, SHALL carry the predicted target; it is meaningful only when predict_taken=1.
REQ-008: Port upd_valid, input, 1, SHALL flag a resolved branch from execute.
REQ-009: Port upd_pc, input, ADDR_W, SHALL carry the PC of the resolved instruction.
REQ-010: Port upd_branch_type, input, 3, SHALL use the pipeline encoding NONE=0, BEQ=1, BNE=2, BLT=3, BGE=4, BLTU=5, BGEU=6.
REQ-011: Port upd_taken, input, 1, SHALL carry the actual outcome from the branch decision logic.
REQ-012: Port upd_target, input, ADDR_W, SHALL carry the actual branch target.
REQ-013: Port upd_pred_taken, input, 1, SHALL carry the prediction that was made for the instruction, piped down to execute.
REQ-014: Port upd_pred_target, input, ADDR_W, SHALL carry the predicted target, piped down to execute.
REQ-015: Port mispredict, output, 1, SHALL flag a redirect request to fetch.

Function
REQ-016: Each entry SHALL hold: valid, tag = pc[ADDR_W-1:IDX_BITS+2], target, and a 2-bit counter.
- Counter states: SNT=00, WNT=01, WT=10, ST=11.
- Entry index = pc[IDX_BITS+1:2].
REQ-017: Lookup SHALL be combinational (zero latency): predict_taken = valid && tag match && counter[1]; predict_target = entry target.
REQ-018: An update SHALL occur at a clock edge when upd_valid=1 and upd_branch_type!=NONE; otherwise the table is unchanged.
REQ-019: On an update that hits (valid && tag match), the counter SHALL saturate-increment if taken and saturate-decrement if not taken.
- ST stays ST when taken.
- SNT stays SNT when not taken.
REQ-020: On an update that misses, the entry SHALL be overwritten: valid=1, new tag, counter = WT if taken, else WNT.
REQ-021: The target field SHALL be written with upd_target only on taken updates; it is retained otherwise.
REQ-022: mispredict SHALL be combinational: update condition && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)).
REQ-023: When lookup and update address the same index in one cycle, lookup SHALL return the pre-update contents (no bypass); the new contents are visible from the next cycle.
REQ-024: Aliasing by index with a differing tag SHALL be handled as a miss: predict not-taken, then replace the entry on update.

Reset
REQ-025: While reset_n=0 at a clock edge, every entry SHALL clear to valid=0, counter=WNT, and target=0.
REQ-026: During reset, predict_taken SHALL be 0; mispredict follows its inputs but causes no state change.
REQ-027: An update coincident with reset SHALL be discarded.

Configuration
REQ-028: With BP_STATS_EN defined, the block SHALL add the following outputs, both cleared by reset and saturating at all-ones:
- stat_branches (32 bits): increments once per update.
- stat_mispredicts (32 bits): increments on each update with mispredict=1.
REQ-029: With BP_STATS_EN undefined, those ports and counters SHALL be absent; prediction behaviour is identical.

Structure
REQ-030: The package branch_pkg SHALL hold the branch-type localparams (NONE..BGEU) and the counter-state enum (SNT/WNT/WT/ST), shared with the branch decision logic.
REQ-031: The 2-bit saturating update SHALL be the sub-module sat_counter2, with inputs cur_state and taken and output next_state.

Verification
REQ-032: After reset, fetch_pc=0x100 -> predict_taken=0.
REQ-033: Update pc=0x100, BEQ, taken, target=0x80 -> mispredict=1 that cycle (pred_taken=0); next cycle fetch_pc=0x100 gives predict_taken=1 and predict_target=0x80.
REQ-034: Four taken updates to 0x100 then one not-taken -> counter ST then WT; prediction is still taken. A second not-taken -> WNT; prediction is not-taken.
REQ-035: Entry at 0x100 trained taken, then update pc=0x100+(4<<IDX_BITS) not-taken -> entry is replaced; lookup of 0x100 gives predict_taken=0.
REQ-036: Same-cycle lookup and update on 0x140 -> lookup shows old value; the next cycle shows the new value. An update with upd_branch_type=NONE -> no change, mispredict=0.
REQ-037: With BP_STATS_EN defined: 10 updates, 3 mispredicted -> stat_branches=10, stat_mispredicts=3. Asserting reset mid-sequence clears both to 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Branch pipeline shared definitions: branch-type encoding and 2-bit counter states.
// Shared by the predictor and the branch decision logic.
package branch_pkg;

    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] BEQ  = 3'd1;
    localparam logic [2:0] BNE  = 3'd2;
    localparam logic [2:0] BLT  = 3'd3;
    localparam logic [2:0] BGE  = 3'd4;
    localparam logic [2:0] BLTU = 3'd5;
    localparam logic [2:0] BGEU = 3'd6;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_state_e;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating counter next-state logic: step toward ST when taken, toward SNT otherwise.
module sat_counter2
    import branch_pkg::*;
(
    input  ctr_state_e cur_state,
    input  logic       taken,
    output ctr_state_e next_state
);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves next_state unassigned (no latch).
        next_state = cur_state;
        unique case (cur_state)
            SNT: next_state = taken ? WNT : SNT;
            WNT: next_state = taken ? WT  : SNT;
            WT:  next_state = taken ? ST  : WNT;
            ST:  next_state = taken ? ST  : WT;
            default: next_state = cur_state;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: tagged BTB entries with 2-bit counters, zero-latency lookup.
// Define BP_STATS_EN to add saturating branch/mispredict statistics outputs.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int ADDR_W   = 32
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              predict_taken,
    output logic [ADDR_W-1:0] predict_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [2:0]        upd_branch_type,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = ADDR_W - IDX_BITS - 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    ctr_state_e        ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0] f_idx, u_idx;
    logic [TAG_W-1:0]    f_tag, u_tag;
    ctr_state_e          f_ctr, u_ctr, u_next;
    logic                upd_en, u_hit;
    logic                unused_pc_bits;

    assign f_idx = fetch_pc[IDX_BITS+1:2];
    assign f_tag = fetch_pc[ADDR_W-1:IDX_BITS+2];
    assign u_idx = upd_pc[IDX_BITS+1:2];
    assign u_tag = upd_pc[ADDR_W-1:IDX_BITS+2];
    assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

    // Lookup reads the registered table, so a same-cycle update is seen only next cycle.
    assign f_ctr          = ctr_q[f_idx];
    assign predict_taken  = reset_n && valid_q[f_idx] && (tag_q[f_idx] == f_tag)
                            && ((f_ctr == WT) || (f_ctr == ST));
    assign predict_target = target_q[f_idx];

    assign upd_en     = upd_valid && (upd_branch_type != NONE);
    assign u_ctr      = ctr_q[u_idx];
    assign u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign mispredict = upd_en && ((upd_pred_taken != upd_taken)
                        || (upd_taken && (upd_pred_target != upd_target)));

    sat_counter2 u_sat (
        .cur_state  (u_ctr),
        .taken      (upd_taken),
        .next_state (u_next)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the whole table is reset, so it must stay in flops; a RAM macro could not clear in one cycle.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
        end else if (upd_en) begin
            if (u_hit) begin
                ctr_q[u_idx] <= u_next;
            end else begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= u_tag;
                ctr_q[u_idx]   <= upd_taken ? WT : WNT;
            end
            if (upd_taken) begin
                target_q[u_idx] <= upd_target;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (upd_en) begin
            if (stat_branches != '1) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule
